bcd_converter: RTL

Sequential binary-to-BCD converter that sits directly downstream of the 256x8 RAM stage. It takes the RAM read data byte and produces hundreds, tens and units digits for the seven-segment `display` decoders. It replaces the combinational `/100`, `%100/10` and `%10` divider chain with an iterative double-dabble (shift-add-3) engine. Handshake is valid/ready on the input side and a one-cycle `out_valid` strobe on the output side; the digit outputs hold until the next conversion completes.

---
 rtl/bcd_converter_if.sv | 26 ++
 rtl/bcd_converter.sv | 95 +++++++++
 2 files changed

// File: rtl/bcd_converter_if.sv
// Handshake and result bundle between the RAM read stage and the binary-to-BCD converter.
// Input side: a word transfers on a rising edge where in_valid and in_ready are both 1;
// in_ready depends only on converter state, and value is sampled solely on that edge.
// Output side: out_valid is a one-cycle strobe; the digits hold until the next strobe.
interface bcd_converter_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] value;
    logic             out_valid;
    logic [3:0]       hundreds;
    logic [3:0]       tens;
    logic [3:0]       units;
    logic             state_dbg;

    modport master (
        output in_valid, value,
        input  in_ready, out_valid, hundreds, tens, units, state_dbg
    );

    modport slave (
        input  in_valid, value,
        output in_ready, out_valid, hundreds, tens, units, state_dbg
    );
endinterface

// File: rtl/bcd_converter.sv
// Iterative double-dabble converter: one shift-add-3 step per cycle, WIDTH cycles per value,
// producing hundreds/tens/units digits for the seven-segment decoders.
module bcd_converter #(
    parameter int WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 resetn,
    bcd_converter_if.slave       bus
);
    typedef enum logic {
        IDLE    = 1'b0,
        CONVERT = 1'b1
    } state_e;

    localparam int CNT_W = 4;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [11:0]      bcd_q, bcd_d;
    logic [11:0]      bcd_adj;
    logic [11:0]      bcd_shifted;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [11:0]      digits_q, digits_d;
    logic             out_valid_q, out_valid_d;
    logic             last_iter;

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.hundreds  = digits_q[11:8];
    assign bus.tens      = digits_q[7:4];
    assign bus.units     = digits_q[3:0];
    assign bus.state_dbg = state_q;

    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    // Each nibble is corrected independently before the shift; the hundreds
    // correction never triggers for inputs up to 255 but is kept uniform.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 3; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        bcd_shifted = (bcd_adj << 1) | 12'(shift_q[WIDTH-1]);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bcd_d       = bcd_q;
        shift_d     = shift_q;
        digits_d    = digits_q;
        out_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    bcd_d   = 12'd0;
                    shift_d = bus.value;
                    cnt_d   = '0;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                bcd_d   = bcd_shifted;
                shift_d = shift_q << 1;
                cnt_d   = cnt_q + 1'b1;
                if (last_iter) begin
                    digits_d    = bcd_shifted;
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bcd_q       <= '0;
            shift_q     <= '0;
            digits_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bcd_q       <= bcd_d;
            shift_q     <= shift_d;
            digits_q    <= digits_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule
